// File: rtl/uart_frame_rx.sv
// ---------------------------------------------------------------------------
// uart_frame_rx
//   UART 8N1 receiver with a frame assembler. Bytes that arrive close
//   together are collected into a buffer. The frame closes once the line
//   has been idle for IDLE_TIMEOUT clocks after the last stop bit. The
//   closed frame is then presented with its length and an error flag.
//
// Ports
//   clock        system clock
//   reset        asynchronous reset, active high
//   rx           UART line (asynchronous to clock, idles high)
//   byte_data    last good received byte
//   byte_valid   one-cycle pulse when byte_data updates
//   frame_data   assembled frame, byte k at [8k+7:8k], byte 0 first received
//   frame_len    number of good bytes stored in the frame
//   frame_valid  one-cycle pulse when a frame closes
//   frame_err    framing error or overflow occurred in the closed frame
// ---------------------------------------------------------------------------
module uart_frame_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int IDLE_TIMEOUT = 50000,
    parameter int MAX_BYTES    = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             rx,
    output logic [7:0]                       byte_data,
    output logic                             byte_valid,
    output logic [8*MAX_BYTES-1:0]           frame_data,
    output logic [$clog2(MAX_BYTES+1)-1:0]   frame_len,
    output logic                             frame_valid,
    output logic                             frame_err
);

    localparam int BT_W  = $clog2(CLKS_PER_BIT);
    localparam int IT_W  = $clog2(IDLE_TIMEOUT);
    localparam int CNT_W = $clog2(MAX_BYTES+1);

    localparam logic [BT_W-1:0]  HALF_M1 = BT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [BT_W-1:0]  FULL_M1 = BT_W'(CLKS_PER_BIT - 1);
    localparam logic [IT_W-1:0]  IDLE_M1 = IT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // rx synchronizer. rxs_d is one more stage, used only to detect the
    // start-bit falling edge. All stages reset to the idle (high) level,
    // so releasing reset cannot look like a start edge.
    // ------------------------------------------------------------------
    logic rx_meta, rxs, rxs_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    wire fall = rxs_d & ~rxs;

    // ------------------------------------------------------------------
    // Bit FSM
    // ------------------------------------------------------------------
    state_t          state, state_n;
    logic [BT_W-1:0] bit_tmr, bit_tmr_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic            stop_sample;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_tmr <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            bit_tmr <= bit_tmr_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_tmr_n   = bit_tmr;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        stop_sample = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_n   = S_START;
                    bit_tmr_n = '0;
                end
            end
            S_START: begin
                // Mid start bit: a high line means the edge was a glitch.
                if (bit_tmr == HALF_M1) begin
                    bit_tmr_n = '0;
                    bit_idx_n = '0;
                    state_n   = rxs ? S_IDLE : S_DATA;
                end else begin
                    bit_tmr_n = bit_tmr + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_tmr == FULL_M1) begin
                    bit_tmr_n = '0;
                    shreg_n   = {rxs, shreg[7:1]};   // LSB arrives first
                    if (bit_idx == 3'd7)
                        state_n = S_STOP;
                    else
                        bit_idx_n = bit_idx + 1'b1;
                end else begin
                    bit_tmr_n = bit_tmr + 1'b1;
                end
            end
            S_STOP: begin
                // Sample at mid stop bit and return to IDLE straight away so
                // the following start edge of a back-to-back byte is seen.
                if (bit_tmr == FULL_M1) begin
                    bit_tmr_n   = '0;
                    stop_sample = 1'b1;
                    state_n     = S_IDLE;
                end else begin
                    bit_tmr_n = bit_tmr + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    wire stop_good = stop_sample &  rxs;
    wire stop_bad  = stop_sample & ~rxs;

    // ------------------------------------------------------------------
    // Frame assembler and idle timer
    // ------------------------------------------------------------------
    logic [MAX_BYTES-1:0][7:0] buffer;
    logic [CNT_W-1:0]          count;
    logic [IT_W-1:0]           idle_tmr;
    logic                      ferr_flag, ovf_flag;
    logic                      active;      // frame open, even with count == 0

    wire wr_en = stop_good && (count != MAX_CNT);
    wire close = active && (state == S_IDLE) && (idle_tmr == IDLE_M1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buffer <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
                if (count == CNT_W'(k))
                    buffer[k] <= shreg;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_data  <= '0;
            frame_len   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            count       <= '0;
            idle_tmr    <= '0;
            ferr_flag   <= 1'b0;
            ovf_flag    <= 1'b0;
            active      <= 1'b0;
        end else begin
            byte_valid  <= stop_good;
            if (stop_good)
                byte_data <= shreg;

            frame_valid <= close;

            // close and stop_sample are exclusive: close needs IDLE, the stop
            // sample happens in STOP. A start edge in the close cycle only
            // moves the bit FSM, so the new byte lands in the next frame.
            if (close) begin
                frame_data <= buffer;
                frame_len  <= count;
                frame_err  <= ferr_flag | ovf_flag;
                count      <= '0;
                ferr_flag  <= 1'b0;
                ovf_flag   <= 1'b0;
                active     <= 1'b0;
                idle_tmr   <= '0;
            end else begin
                // Timer runs only between bytes; while a byte is in flight it
                // freezes and that byte's stop sample restarts it.
                if (stop_sample) begin
                    idle_tmr <= '0;
                    active   <= 1'b1;
                end else if (active && state == S_IDLE) begin
                    idle_tmr <= idle_tmr + 1'b1;
                end else if (!active) begin
                    idle_tmr <= '0;
                end

                if (wr_en)
                    count <= count + 1'b1;
                if (stop_good && count == MAX_CNT)
                    ovf_flag <= 1'b1;     // count saturates, byte dropped
                if (stop_bad)
                    ferr_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;

    localparam int CPB  = 16;
    localparam int IDLE = 400;
    localparam int MB   = 16;
    localparam int FW   = 8*MB;
    localparam int LW   = $clog2(MB+1);

    logic          clock, reset, rx;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic [FW-1:0] frame_data;
    logic [LW-1:0] frame_len;
    logic          frame_valid, frame_err;

    uart_frame_rx #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT(IDLE), .MAX_BYTES(MB)) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .frame_data(frame_data), .frame_len(frame_len),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // ---------------- output monitor (samples on falling edge) ----------
    int            ncyc = 0;
    int            bv_cyc = 0;
    int            fv_cyc = 0;
    logic [7:0]    byte_q[$];
    logic [FW-1:0] fr_data_q[$];
    logic [LW-1:0] fr_len_q[$];
    logic          fr_err_q[$];

    always @(negedge clock) begin
        ncyc <= ncyc + 1;
        if (byte_valid) begin
            byte_q.push_back(byte_data);
            bv_cyc <= ncyc;
        end
        if (frame_valid) begin
            fr_data_q.push_back(frame_data);
            fr_len_q.push_back(frame_len);
            fr_err_q.push_back(frame_err);
            fv_cyc <= ncyc;
        end
    end

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_q();
        byte_q.delete();
        fr_data_q.delete();
        fr_len_q.delete();
        fr_err_q.delete();
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input int gap);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time(stop);
        rx = 1'b1;
        repeat (gap) @(negedge clock);
    endtask

    task automatic settle();
        repeat (IDLE + 60) @(negedge clock);
    endtask

    function automatic logic [FW-1:0] fd(input int i);
        return (fr_data_q.size() > i) ? fr_data_q[i] : '1;
    endfunction
    function automatic logic [LW-1:0] fl(input int i);
        return (fr_len_q.size() > i) ? fr_len_q[i] : '1;
    endfunction
    function automatic logic fe(input int i);
        return (fr_err_q.size() > i) ? fr_err_q[i] : 1'bx;
    endfunction
    function automatic logic [7:0] bq(input int i);
        return (byte_q.size() > i) ? byte_q[i] : 8'hxx;
    endfunction

    // ---------------- single-byte vector table --------------------------
    typedef struct {
        logic [7:0]    data;
        logic          stop;
        int            exp_nbytes;
        logic [LW-1:0] exp_len;
        logic          exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        string         s;
        logic [FW-1:0] exp;

        vecs[0] = '{8'h35, 1'b1, 1, 5'd1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1, 5'd1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1, 5'd1, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1, 5'd1, 1'b0};
        vecs[4] = '{8'h33, 1'b0, 0, 5'd0, 1'b1};  // frame of only an error

        rx    = 1'b1;
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (4) @(negedge clock);
        check("rst byte_data",   FW'(byte_data),   '0);
        check("rst byte_valid",  FW'(byte_valid),  '0);
        check("rst frame_data",  frame_data,       '0);
        check("rst frame_len",   FW'(frame_len),   '0);
        check("rst frame_valid", FW'(frame_valid), '0);
        check("rst frame_err",   FW'(frame_err),   '0);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        for (int v = 0; v < 5; v++) begin
            clear_q();
            send_byte(vecs[v].data, vecs[v].stop, CPB);
            settle();
            check($sformatf("v%0d nbytes", v), FW'(byte_q.size()), FW'(vecs[v].exp_nbytes));
            if (vecs[v].exp_nbytes > 0)
                check($sformatf("v%0d byte", v), FW'(bq(0)), FW'(vecs[v].data));
            check($sformatf("v%0d nframes", v), FW'(fr_len_q.size()), FW'(1));
            check($sformatf("v%0d len", v), FW'(fl(0)), FW'(vecs[v].exp_len));
            check($sformatf("v%0d err", v), FW'(fe(0)), FW'(vecs[v].exp_err));
            if (vecs[v].exp_nbytes > 0) begin
                check($sformatf("v%0d fdata0", v), FW'(fd(0) & FW'(8'hFF)), FW'(vecs[v].data));
                check($sformatf("v%0d latency", v), FW'(fv_cyc - bv_cyc), FW'(IDLE));
            end
        end

        // 16-byte banner back-to-back
        clear_q();
        s = "** Thanh Hung **";
        exp = '0;
        for (int i = 0; i < 16; i++) begin
            exp[8*i +: 8] = s[i];
            send_byte(s[i], 1'b1, 0);
        end
        settle();
        check("str nbytes",  FW'(byte_q.size()), FW'(16));
        check("str nframes", FW'(fr_len_q.size()), FW'(1));
        check("str len",     FW'(fl(0)), FW'(16));
        check("str err",     FW'(fe(0)), FW'(0));
        check("str data",    fd(0), exp);
        check("str b0",      FW'(fd(0) & FW'(8'hFF)), FW'(8'h2A));
        check("str b15",     FW'(fd(0) >> 120), FW'(8'h2A));
        check("str b3",      FW'((fd(0) >> 24) & FW'(8'hFF)), FW'(8'h54));

        // 18 bytes overflow the 16-byte buffer
        clear_q();
        exp = '0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) exp[8*i +: 8] = 8'(8'h41 + i);
            send_byte(8'(8'h41 + i), 1'b1, 0);
        end
        settle();
        check("ovf nbytes",  FW'(byte_q.size()), FW'(18));
        check("ovf nframes", FW'(fr_len_q.size()), FW'(1));
        check("ovf len",     FW'(fl(0)), FW'(16));
        check("ovf err",     FW'(fe(0)), FW'(1));
        check("ovf data",    fd(0), exp);
        check("ovf b15",     FW'(fd(0) >> 120), FW'(8'h50));

        // short low glitch, then a real byte
        clear_q();
        rx = 1'b0;
        repeat (CPB/4) @(negedge clock);
        rx = 1'b1;
        settle();
        check("glitch nbytes",  FW'(byte_q.size()), FW'(0));
        check("glitch nframes", FW'(fr_len_q.size()), FW'(0));
        send_byte(8'h31, 1'b1, CPB);
        settle();
        check("post-glitch nbytes", FW'(byte_q.size()), FW'(1));
        check("post-glitch byte",   FW'(bq(0)), FW'(8'h31));
        check("post-glitch len",    FW'(fl(0)), FW'(1));
        check("post-glitch err",    FW'(fe(0)), FW'(0));

        // bad stop bit followed by a good byte in the same frame
        clear_q();
        send_byte(8'h33, 1'b0, CPB);
        send_byte(8'h34, 1'b1, CPB);
        settle();
        check("ferr nbytes",  FW'(byte_q.size()), FW'(1));
        check("ferr byte",    FW'(bq(0)), FW'(8'h34));
        check("ferr nframes", FW'(fr_len_q.size()), FW'(1));
        check("ferr len",     FW'(fl(0)), FW'(1));
        check("ferr b0",      FW'(fd(0) & FW'(8'hFF)), FW'(8'h34));
        check("ferr err",     FW'(fe(0)), FW'(1));

        // gap of half the timeout keeps one frame
        clear_q();
        send_byte(8'h61, 1'b1, IDLE/2);
        send_byte(8'h62, 1'b1, CPB);
        settle();
        check("gap-short nframes", FW'(fr_len_q.size()), FW'(1));
        check("gap-short len",     FW'(fl(0)), FW'(2));
        check("gap-short data",    FW'(fd(0) & FW'(16'hFFFF)), FW'(16'h6261));

        // gap of twice the timeout splits into two frames
        clear_q();
        send_byte(8'h63, 1'b1, 2*IDLE);
        send_byte(8'h64, 1'b1, CPB);
        settle();
        check("gap-long nframes", FW'(fr_len_q.size()), FW'(2));
        check("gap-long len0",    FW'(fl(0)), FW'(1));
        check("gap-long len1",    FW'(fl(1)), FW'(1));
        check("gap-long b0",      FW'(fd(0) & FW'(8'hFF)), FW'(8'h63));
        check("gap-long b1",      FW'(fd(1) & FW'(8'hFF)), FW'(8'h64));

        // reset in the middle of a byte's data bits
        clear_q();
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        rx = 1'b1;
        repeat (CPB/2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst byte_data",  FW'(byte_data),  '0);
        check("midrst frame_data", frame_data,      '0);
        check("midrst frame_len",  FW'(frame_len),  '0);
        check("midrst frame_err",  FW'(frame_err),  '0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        settle();
        check("midrst nbytes",  FW'(byte_q.size()), FW'(0));
        check("midrst nframes", FW'(fr_len_q.size()), FW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Self-contained UART receive path: bit-level 8N1 deserializer plus frame assembler.
- Collects consecutive bytes into a buffer and closes the frame after an idle gap on the line.
- Presents the whole frame, its length and an error flag to the control layer.
- Counterpart of the string-transmit sequencer: receives multi-byte strings (e.g. 16-char banners) that a peer sends back-to-back.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per UART bit (50 MHz / 9600 baud).
- IDLE_TIMEOUT, 50000: idle clocks after the last byte that close a frame (1 ms at 50 MHz).
- MAX_BYTES, 16: frame buffer depth in bytes.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous reset, active-high.
- rx, input, 1: UART line, asynchronous to clock, idles high.
- byte_data, output, 8: last good received byte.
- byte_valid, output, 1: one-cycle pulse when byte_data updates.
- frame_data, output, 8*MAX_BYTES: assembled frame; byte k at bits [8k+7:8k]; byte 0 is the first received.
- frame_len, output, $clog2(MAX_BYTES+1): number of good bytes stored in the frame.
- frame_valid, output, 1: one-cycle pulse when a frame closes.
- frame_err, output, 1: framing error or overflow occurred in this frame.

Behaviour:
- Reset:
  - All outputs 0.
  - rx synchronizer stages set to 1.
  - Bit FSM in IDLE; byte count, idle timer and error flags 0.
- Input sync: 2-FF synchronizer on rx. All logic uses the synced value rxs, which adds 2 cycles of latency.
- Bit FSM states and transitions:
  - IDLE: rxs falling edge -> START, bit timer 0.
  - START: at timer = CLKS_PER_BIT/2-1, sample rxs. 0 -> DATA with timer 0 and bit index 0. 1 (glitch) -> IDLE, nothing reported.
  - DATA: every CLKS_PER_BIT clocks, sample rxs into the shift register, LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT clocks (mid stop bit), sample rxs and go to IDLE the same cycle, so back-to-back bytes are not missed.
    - Stop = 1: byte_data <= shift register, byte_valid = 1 for the next cycle.
    - Stop = 0: byte discarded, no byte_valid, frame error flag set.
- Frame assembler:
  - Good byte with count < MAX_BYTES: write to buffer[count], count++.
  - Good byte with count = MAX_BYTES: byte discarded, overflow flag set; count saturates.
  - Framing error and overflow both mark the frame as active even when count = 0.
- Idle timer:
  - Cleared on every stop-bit sample, good or bad.
  - Increments only while the bit FSM is in IDLE and a frame is active.
  - Held at 0 when no frame is active.
- Frame close, when timer = IDLE_TIMEOUT-1:
  - frame_data <= buffer, frame_len <= count, frame_err <= framing flag | overflow flag.
  - frame_valid = 1 for one cycle.
  - Count, flags and timer cleared.
  - frame_data, frame_len and frame_err then hold until the next close.
- Simultaneous events:
  - A start edge in the close cycle: the close completes, and the new byte belongs to the next frame at index 0.
  - A start edge before the timeout: the timer freezes and is cleared at that byte's stop sample.
- Unused buffer bytes are not cleared between frames; frame_len defines the valid span.
- Reset mid-byte or mid-frame: partial byte and frame dropped, no frame_valid.
- byte_valid and frame_valid never pulse within 2 cycles after reset release.

Test Plan:
- Send 0x35 ("5") at CLKS_PER_BIT=5208 -> byte_valid pulse with byte_data=0x35; frame_valid IDLE_TIMEOUT clocks after the stop sample; frame_len=1, frame_data[7:0]=0x35, frame_err=0.
- Send "** Thanh Hung **" back-to-back (16 bytes, no gap) -> 16 byte_valid pulses, one frame_valid, frame_len=16, frame_data[7:0]=0x2A, frame_data[127:120]=0x2A, frame_data[31:24]=0x54, frame_err=0.
- Send 18 bytes 0x41..0x52 -> frame_len=16, frame_err=1, byte 15 = 0x50; 0x51 and 0x52 absent.
- rx low pulse of CLKS_PER_BIT/4 clocks -> no byte_valid, no frame_valid; a following valid 0x31 is received correctly.
- Byte 0x33 with stop bit 0, then good 0x34 -> only one byte_valid (0x34); frame_len=1, frame_data[7:0]=0x34, frame_err=1.
- Two bytes with a 0.5 ms gap -> one frame, len 2. Same with a 2 ms gap -> two frames, len 1 each. Reset asserted mid-DATA -> all outputs 0 and no frame_valid for that byte.
